// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder side of the pipeline load/store port. Serves one MEM-stage access at
//   a time over a valid/ready request/response handshake, with LATENCY cycles from
//   request accept to resp_valid. Holds DEPTH 64-bit doublewords, supports
//   byte/half/word/double lanes with sign/zero extension on loads, and flags
//   misaligned or out-of-range accesses.
//
//   Build option: define DMEM_ZERO_WAIT_EN to ignore LATENCY and answer every
//   request in the cycle right after it is accepted.
//
// Ports
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   req_valid     initiator presents a request
//   req_ready     responder can accept (high only when idle)
//   req_write     1 = store, 0 = load
//   req_addr      byte address (64 bits)
//   req_size      0=byte 1=half 2=word 3=double
//   req_unsigned  zero-extend loads when 1
//   req_wdata     store data, right-aligned
//   resp_valid    response available
//   resp_ready    initiator takes the response
//   resp_rdata    extended load data; 0 for stores and errors
//   resp_err      misaligned or out-of-range access
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAST_CNT   = 4'(LATENCY - 1);
`ifdef DMEM_ZERO_WAIT_EN
  localparam bit          NO_WAIT    = 1'b1;
`else
  localparam bit          NO_WAIT    = (LATENCY <= 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;

  logic        cap_write;
  logic [63:0] cap_addr;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [63:0] cap_wdata;

  logic [63:0] mem [DEPTH];

  // The access is resolved either at the accept edge (no wait states) or at the
  // last WAIT edge, so the datapath works on live inputs while idle and on the
  // captured request otherwise.
  logic        src_write, src_unsigned;
  logic [63:0] src_addr, src_wdata;
  logic [1:0]  src_size;

  assign src_write    = (state == IDLE) ? req_write    : cap_write;
  assign src_addr     = (state == IDLE) ? req_addr     : cap_addr;
  assign src_size     = (state == IDLE) ? req_size     : cap_size;
  assign src_unsigned = (state == IDLE) ? req_unsigned : cap_unsigned;
  assign src_wdata    = (state == IDLE) ? req_wdata    : cap_wdata;

  logic             misaligned, src_err, finish, commit;
  logic [IDX_W-1:0] idx;
  logic [5:0]       shamt;
  logic [63:0]      old_word, lane_mask, shifted_mask, merged, raw, ext, load_data;

  assign idx      = src_addr[3 +: IDX_W];
  assign shamt    = {src_addr[2:0], 3'b000};
  assign old_word = mem[idx];

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = '1;
    ext        = raw;
    case (src_size)
      2'd0: begin
        lane_mask = 64'h0000_0000_0000_00FF;
        ext       = src_unsigned ? {56'd0, raw[7:0]} : {{56{raw[7]}}, raw[7:0]};
      end
      2'd1: begin
        misaligned = src_addr[0];
        lane_mask  = 64'h0000_0000_0000_FFFF;
        ext        = src_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      end
      2'd2: begin
        misaligned = |src_addr[1:0];
        lane_mask  = 64'h0000_0000_FFFF_FFFF;
        ext        = src_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      end
      default: begin
        misaligned = |src_addr[2:0];
      end
    endcase
  end

  assign src_err      = misaligned || (src_addr >= BYTE_LIMIT);
  assign shifted_mask = lane_mask << shamt;
  // Read-modify-write keeps the bytes outside the addressed lanes intact.
  assign merged       = (old_word & ~shifted_mask) | ((src_wdata << shamt) & shifted_mask);
  assign raw          = old_word >> shamt;
  assign load_data    = (src_err || src_write) ? 64'd0 : ext;

  assign finish = ((state == IDLE) && req_valid && NO_WAIT) ||
                  ((state == WAIT) && (wait_cnt == LAST_CNT));
  assign commit = finish && src_write && !src_err;

  // State register plus the request capture and response registers. A reset
  // during WAIT returns to IDLE before the commit edge, so the store is lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      resp_rdata   <= 64'd0;
      resp_err     <= 1'b0;
      cap_write    <= 1'b0;
      cap_addr     <= 64'd0;
      cap_size     <= 2'd0;
      cap_unsigned <= 1'b0;
      cap_wdata    <= 64'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if ((state == IDLE) && req_valid) begin
        cap_write    <= req_write;
        cap_addr     <= req_addr;
        cap_size     <= req_size;
        cap_unsigned <= req_unsigned;
        cap_wdata    <= req_wdata;
      end
      if (finish) begin
        resp_rdata <= load_data;
        resp_err   <= src_err;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (commit) begin
      mem[idx] <= merged;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (NO_WAIT) begin
            state_nxt = RESP;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 4'd1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == LAST_CNT) begin
          state_nxt    = RESP;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder: reset values, a table of directed
//   accesses, a stalled-response sequence, a reset-during-wait sequence and
//   randomized accesses checked against a byte-addressed memory model.
//   Define DMEM_ZERO_WAIT_EN for both bench and design to check the zero-wait build.
module tb_data_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
`ifdef DMEM_ZERO_WAIT_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = LATENCY;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  // Byte-addressed little-endian reference memory.
  logic [7:0] mbytes [logic [63:0]];

  function automatic void model_access(input logic wr, input logic [63:0] addr,
                                       input logic [1:0] size, input logic uns,
                                       input logic [63:0] wdata,
                                       output logic [63:0] rdata, output logic err);
    int n;
    n     = 1 << size;
    err   = ((addr % 64'(n)) != 64'd0) || (addr >= 64'(DEPTH) * 64'd8);
    rdata = 64'd0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mbytes[addr + 64'(i)] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rdata = rdata | (64'(mbytes[addr + 64'(i)]) << (8*i));
        if (!uns && n < 8 && rdata[8*n-1]) rdata = rdata | ~((64'd1 << (8*n)) - 64'd1);
      end
    end
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // One complete access. Request fields are scrambled right after the accept
  // edge; hold keeps resp_ready low that many cycles; poke offers a store
  // while the response is pending, which must be ignored.
  task automatic apply_stimulus(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                                input logic uns, input logic [63:0] wdata, input int hold,
                                input bit poke, output logic [63:0] rdata, output logic err,
                                output int lat);
    int guard;
    bit got;
    rdata = 64'd0;
    err   = 1'b0;
    lat   = -1;
    @(negedge clock);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      flag_timeout("accept");
      return;
    end
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clock);
    #1;
    req_valid    = 1'b0;
    req_write    = ~wr;
    req_addr     = {$urandom, $urandom};
    req_size     = 2'($urandom);
    req_unsigned = ~uns;
    req_wdata    = {$urandom, $urandom};
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      flag_timeout("response");
      return;
    end
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_output("hold_stable", {61'd0, req_ready, resp_valid, resp_err, resp_rdata},
                   {61'd0, 1'b0, 1'b1, err, rdata});
      if (poke && i == 1) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_size  = 2'd3;
        req_wdata = 64'hBADB_ADBA_DBAD_BAD0;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    @(negedge clock);
    check_output("handoff", {126'd0, req_ready, resp_valid}, {126'd0, 2'b10});
  endtask

  task automatic run_model_check(input string name, input logic wr, input logic [63:0] addr,
                                 input logic [1:0] size, input logic uns,
                                 input logic [63:0] wdata, input int hold);
    logic [63:0] exp_rdata, act_rdata;
    logic        exp_err, act_err;
    int          lat;
    model_access(wr, addr, size, uns, wdata, exp_rdata, exp_err);
    apply_stimulus(wr, addr, size, uns, wdata, hold, 1'b0, act_rdata, act_err, lat);
    check_output({name, "_rdata"}, {64'd0, act_rdata}, {64'd0, exp_rdata});
    check_output({name, "_err"}, {127'd0, act_err}, {127'd0, exp_err});
    check_output({name, "_latency"}, 128'(lat), 128'(EXP_LAT));
  endtask

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rd, mrd;
    logic        er, merr;
    int          lat;
    logic [1:0]  sz;
    logic [63:0] ad;
    int          sel;

    // Reset state
    repeat (3) @(negedge clock);
    check_output("reset_outputs", {60'd0, req_ready, resp_valid, resp_err, 1'b0, resp_rdata},
                 {60'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
    reset_n = 1'b1;
    @(negedge clock);
    check_output("after_reset", {126'd0, req_ready, resp_valid}, {126'd0, 2'b10});

    // Known contents for the low region and the last doubleword
    for (int i = 0; i < 64; i++)
      run_model_check("fill", 1'b1, 64'(i * 8), 2'd3, 1'b0, {$urandom, $urandom}, 0);
    run_model_check("fill_top", 1'b1, 64'h1FF8, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 0);

    // Directed table
    add_vec(1, 64'hF8,  3, 0, 64'h1122_3344_5566_7788, 64'd0, 0);
    add_vec(0, 64'hF8,  3, 0, 64'd0, 64'h1122_3344_5566_7788, 0);
    add_vec(1, 64'h100, 3, 0, 64'd0, 64'd0, 0);
    add_vec(1, 64'h101, 0, 0, 64'h1234_5678_90AB_CD80, 64'd0, 0);
    add_vec(0, 64'h101, 0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 0);
    add_vec(0, 64'h101, 0, 1, 64'd0, 64'h0000_0000_0000_0080, 0);
    add_vec(0, 64'h100, 3, 0, 64'd0, 64'h0000_0000_0000_8000, 0);
    add_vec(0, 64'h102, 2, 0, 64'd0, 64'd0, 1);
    add_vec(1, 64'h2000, 3, 0, 64'hDEAD, 64'd0, 1);
    add_vec(0, 64'h1FF8, 3, 0, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
    add_vec(1, 64'h104, 2, 0, 64'hFFFF_FFFF_8765_4321, 64'd0, 0);
    add_vec(0, 64'h104, 2, 0, 64'd0, 64'hFFFF_FFFF_8765_4321, 0);
    add_vec(0, 64'h104, 2, 1, 64'd0, 64'h0000_0000_8765_4321, 0);
    add_vec(0, 64'h106, 1, 0, 64'd0, 64'hFFFF_FFFF_FFFF_8765, 0);
    add_vec(0, 64'h106, 1, 1, 64'd0, 64'h0000_0000_0000_8765, 0);
    add_vec(0, 64'h100, 3, 0, 64'd0, 64'h8765_4321_0000_8000, 0);
    add_vec(0, 64'h101, 1, 0, 64'd0, 64'd0, 1);
    add_vec(0, 64'hFFFF_FFFF_FFFF_FFF8, 3, 0, 64'd0, 64'd0, 1);
    add_vec(1, 64'h10,  3, 0, 64'h5555_AAAA_5555_AAAA, 64'd0, 0);
    add_vec(0, 64'h10,  3, 0, 64'd0, 64'h5555_AAAA_5555_AAAA, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                     0, 1'b0, rd, er, lat);
      check_output($sformatf("vec%0d_rdata", i), {64'd0, rd}, {64'd0, vecs[i].exp_rdata});
      check_output($sformatf("vec%0d_err", i), {127'd0, er}, {127'd0, vecs[i].exp_err});
      check_output($sformatf("vec%0d_latency", i), 128'(lat), 128'(EXP_LAT));
      model_access(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, mrd, merr);
    end

    // Stalled response with an ignored request in the stall window
    apply_stimulus(1'b0, 64'hF8, 2'd3, 1'b0, 64'd0, 5, 1'b1, rd, er, lat);
    check_output("stall_rdata", {64'd0, rd}, {64'd0, 64'h1122_3344_5566_7788});
    run_model_check("after_poke", 1'b0, 64'hF8, 2'd3, 1'b0, 64'd0, 0);

    // Reset while the store is still waiting
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_size = 2'd3;
    req_unsigned = 1'b0; req_wdata = 64'hAB;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_output("midreset_outputs", {60'd0, req_ready, resp_valid, resp_err, 1'b0, resp_rdata},
                 {60'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
`ifdef DMEM_ZERO_WAIT_EN
    model_access(1'b1, 64'h10, 2'd3, 1'b0, 64'hAB, mrd, merr);
`endif
    apply_stimulus(1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0, 1'b0, rd, er, lat);
`ifdef DMEM_ZERO_WAIT_EN
    check_output("midreset_load", {64'd0, rd}, {64'd0, 64'hAB});
`else
    check_output("midreset_load", {64'd0, rd}, {64'd0, 64'h5555_AAAA_5555_AAAA});
`endif
    check_output("midreset_latency", 128'(lat), 128'(EXP_LAT));

    // Randomized accesses against the model
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 9));
      sz  = 2'($urandom_range(0, 3));
      if (sel < 7)       ad = 64'($urandom_range(0, 511)) & ~((64'd1 << sz) - 64'd1);
      else if (sel == 7) ad = 64'($urandom_range(0, 511));
      else if (sel == 8) ad = (64'h2000 + 64'($urandom_range(0, 255))) & ~((64'd1 << sz) - 64'd1);
      else               ad = {$urandom, $urandom};
      run_model_check("rand", 1'($urandom), ad, sz, 1'($urandom), {$urandom, $urandom},
                      int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
